serial_sub_ctrl: RTL and testbench

//   Sequencer for the 1-bit NAND full-subtractor cell.

---
 rtl/serial_sub_ctrl.sv | 95 +++++++++
 tb/tb_serial_sub_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor sequencer: computes a - b - bin LSB first
// through a single full-subtractor cell, with a registered borrow between bits.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_nxt;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit;
  logic             bo_bit;

  // Single full-subtractor cell on the current LSBs; diff fills from the MSB
  // so that after WIDTH shifts bit 0 holds the first processed bit.
  always_comb begin
    d_bit             = a_sr[0] ^ b_sr[0] ^ br;
    bo_bit            = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    diff_nxt          = diff >> 1;
    diff_nxt[WIDTH-1] = d_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      br    <= 1'b0;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          diff <= diff_nxt;
          br   <= bo_bit;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            bout  <= bo_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start1 = 1'b0, bin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  diff;
    logic        bout;
    int unsigned due;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain signed integer subtraction; a negative result is a borrow.
  function automatic exp_t model(input int av, input int bv, input int binv,
                                 input int w, input int unsigned due);
    exp_t e;
    int r;
    r      = av - bv - binv;
    e.diff = 8'(r & ((1 << w) - 1));
    e.bout = (r < 0);
    e.due  = due;
    return e;
  endfunction

  int unsigned busycnt8 = 0;
  int unsigned busycnt1 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busycnt8 = 0;
    end else begin
      if (busy8) busycnt8++;
      if (done8) begin
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done8 actual=done required=no_done (t=%0t)", $time);
        end else begin
          e = q8.pop_front();
          chk("diff8", 32'(diff8), 32'(e.diff));
          chk("bout8", 32'(bout8), 32'(e.bout));
          chk("latency8", cyc, e.due);
          chk("busy_cycles8", busycnt8, 8);
          chk("busy_during_done8", 32'(busy8), 0);
        end
        busycnt8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busycnt1 = 0;
    end else begin
      if (busy1) busycnt1++;
      if (done1) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done1 actual=done required=no_done (t=%0t)", $time);
        end else begin
          e = q1.pop_front();
          chk("diff1", 32'(diff1), 32'(e.diff));
          chk("bout1", 32'(bout1), 32'(e.bout));
          chk("latency1", cyc, e.due);
          chk("busy_cycles1", busycnt1, 1);
        end
        busycnt1 = 0;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic binv);
    a8 = av; b8 = bv; bin8 = binv; start8 = 1'b1;
    @(posedge clk); #1;
    q8.push_back(model(int'(av), int'(bv), int'(binv), 8, cyc + 8));
  endtask

  task automatic issue1(input logic av, input logic bv, input logic binv);
    a1 = av; b1 = bv; bin1 = binv; start1 = 1'b1;
    @(posedge clk); #1;
    q1.push_back(model(int'(av), int'(bv), int'(binv), 1, cyc + 1));
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_done8", 32'(done8), 0);
    chk("rst_diff8", 32'(diff8), 0);
    chk("rst_bout8", 32'(bout8), 0);
    chk("rst_busy1", 32'(busy1), 0);
    #11 rst = 1'b0;
    edges(1);

    // Directed operands, including underflow and borrow-in only.
    issue8(8'd5, 8'd3, 1'b0);   start8 = 1'b0; edges(9);
    issue8(8'd3, 8'd5, 1'b0);   start8 = 1'b0; edges(9);
    issue8(8'd0, 8'd0, 1'b1);   start8 = 1'b0; edges(9);
    issue8(8'hFF, 8'h00, 1'b1); start8 = 1'b0; edges(9);
    issue8(8'h80, 8'h7F, 1'b0); start8 = 1'b0; edges(9);

    // Start and operand noise while running must not affect the captured op.
    issue8(8'h9A, 8'h3C, 1'b1);
    for (int i = 0; i < 8; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      start8 = 1'($urandom);
      edges(1);
    end
    start8 = 1'b0;
    edges(2);

    // Asynchronous reset between edges mid-RUN aborts with no done.
    issue8(8'hC8, 8'h37, 1'b0);
    start8 = 1'b0;
    edges(2);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy8", 32'(busy8), 0);
    chk("abort_done8", 32'(done8), 0);
    chk("abort_diff8", 32'(diff8), 0);
    chk("abort_bout8", 32'(bout8), 0);
    q8.delete();
    #2 rst = 1'b0;
    edges(12);
    issue8(8'h41, 8'h29, 1'b1); start8 = 1'b0; edges(9);

    // Back-to-back stream with start held high.
    for (int i = 0; i < 100; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom));
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      edges(9);
    end
    start8 = 1'b0;
    edges(12);

    // WIDTH=1: full-subtractor truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      issue1(v[2], v[1], v[0]);
      start1 = 1'b0;
      edges(2);
    end
    edges(4);

    chk("queue8_empty", q8.size(), 0);
    chk("queue1_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
